// File: rtl/use_dispatch_pkg.sv
// Shared width helpers and record type for the stream-element to compression-engine dispatch path.
package use_dispatch_pkg;

  function automatic int count_width(input int max_bytes);
    return $clog2(max_bytes + 32'sd1);
  endfunction

  // A single engine still needs a 1-bit id so the order FIFO stays non-degenerate.
  function automatic int id_width(input int num_ids);
    return (num_ids > 32'sd1) ? $clog2(num_ids) : 32'sd1;
  endfunction

  localparam int DEFAULT_MAX_BYTES = 34;
  localparam int DEFAULT_COUNT_W   = count_width(DEFAULT_MAX_BYTES);

  typedef struct packed {
    logic [DEFAULT_MAX_BYTES*8-1:0] data;
    logic [DEFAULT_COUNT_W-1:0]     byte_count;
  } record_t;

endpackage

// File: rtl/use_dispatch_arbiter_if.sv
// Record, engine handshake and order-log bundle between the USE array, the arbiter and the CEs.
interface use_dispatch_arbiter_if
  import use_dispatch_pkg::*;
#(
  parameter int NUM_STREAM_ELEMENTS      = 4,
  parameter int NUM_COMPRESSION_ELEMENTS = 2,
  parameter int MAX_UNCOMPRESSED_BYTES   = 34
);
  localparam int CW = count_width(MAX_UNCOMPRESSED_BYTES);
  localparam int IW = id_width(NUM_COMPRESSION_ELEMENTS);
  localparam int DW = MAX_UNCOMPRESSED_BYTES * 8;

  logic [NUM_STREAM_ELEMENTS-1:0][DW-1:0]      use_data;
  logic [NUM_STREAM_ELEMENTS-1:0][CW-1:0]      use_byte_count;
  logic [NUM_STREAM_ELEMENTS-1:0]              use_taken;
  logic [NUM_COMPRESSION_ELEMENTS-1:0][DW-1:0] ce_data;
  logic [NUM_COMPRESSION_ELEMENTS-1:0][CW-1:0] ce_byte_count;
  logic [NUM_COMPRESSION_ELEMENTS-1:0]         ce_valid;
  logic [NUM_COMPRESSION_ELEMENTS-1:0]         ce_ready;
  logic [IW-1:0]                               order_id;
  logic                                        order_valid;
  logic                                        order_ready;
  logic [31:0]                                 dispatch_count;

  modport master (
    input  use_data, use_byte_count, ce_ready, order_ready,
    output use_taken, ce_data, ce_byte_count, ce_valid, order_id, order_valid, dispatch_count
  );

  modport slave (
    output use_data, use_byte_count, ce_ready, order_ready,
    input  use_taken, ce_data, ce_byte_count, ce_valid, order_id, order_valid, dispatch_count
  );

endinterface

// File: rtl/use_dispatch_arbiter_order_fifo.sv
// Synchronous FIFO logging the engine index of each dispatched record, oldest at the head.
module dispatch_order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1'b1);

  logic [AW:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW:0]                 rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        empty_s;
  logic                        full_s;

  // The extra pointer MSB separates full (wrapped) from empty (equal).
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign full  = full_s;
  assign valid = !empty_s;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/use_dispatch_arbiter.sv
// Pulls records from the USE ring in strict token order and hands each to the next free
// compression engine, logging the engine index so the return path can restore stream order.
module use_dispatch_arbiter
  import use_dispatch_pkg::*;
#(
  parameter int NUM_STREAM_ELEMENTS      = 4,
  parameter int NUM_COMPRESSION_ELEMENTS = 2,
  parameter int MAX_UNCOMPRESSED_BYTES   = 34,
  parameter int ORDER_FIFO_DEPTH         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  use_dispatch_arbiter_if.master bus
);
  localparam int CW = count_width(MAX_UNCOMPRESSED_BYTES);
  localparam int IW = id_width(NUM_COMPRESSION_ELEMENTS);
  localparam int PW = $clog2(NUM_STREAM_ELEMENTS);
  localparam int DW = MAX_UNCOMPRESSED_BYTES * 8;
  localparam logic [PW-1:0] LAST_USE = PW'(NUM_STREAM_ELEMENTS - 1);
  localparam logic [IW-1:0] LAST_CE  = IW'(NUM_COMPRESSION_ELEMENTS - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] byte_count;
  } slot_t;

  logic [PW-1:0]                         use_ptr_q, use_ptr_d;
  logic [IW-1:0]                         eng_ptr_q, eng_ptr_d;
  logic [NUM_COMPRESSION_ELEMENTS-1:0]   ce_valid_q, ce_valid_d;
  slot_t [NUM_COMPRESSION_ELEMENTS-1:0]  slot_q, slot_d;
  logic [31:0]                           dispatch_count_q, dispatch_count_d;
  logic [CW-1:0]                         cur_count_s;
  logic [IW-1:0]                         sel_s;
  logic                                  found_s;
  logic                                  dispatch_s;
  logic                                  fifo_full_s;
  logic                                  fifo_valid_s;
  logic [IW-1:0]                         fifo_head_s;
  logic [NUM_STREAM_ELEMENTS-1:0]        use_taken_s;

  // Free-slot scan is based on registered valids, so a slot drained this cycle waits a cycle.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int i = 0; i < NUM_COMPRESSION_ELEMENTS; i++) begin
      if (!found_s && !ce_valid_q[(int'(eng_ptr_q) + i) % NUM_COMPRESSION_ELEMENTS]) begin
        found_s = 1'b1;
        sel_s   = IW'((int'(eng_ptr_q) + i) % NUM_COMPRESSION_ELEMENTS);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Reset gates the take pulse so no USE releases a record while the arbiter is held.
  assign cur_count_s = bus.use_byte_count[use_ptr_q];
  assign dispatch_s  = reset && (cur_count_s != '0) && found_s && !fifo_full_s;

  always_comb begin
    use_taken_s      = '0;
    use_ptr_d        = use_ptr_q;
    eng_ptr_d        = eng_ptr_q;
    ce_valid_d       = ce_valid_q;
    slot_d           = slot_q;
    dispatch_count_d = dispatch_count_q;
    for (int e = 0; e < NUM_COMPRESSION_ELEMENTS; e++) begin
      if (ce_valid_q[e] && bus.ce_ready[e]) begin
        ce_valid_d[e] = 1'b0;
      end else begin
        ce_valid_d[e] = ce_valid_q[e];
      end
    end
    if (dispatch_s) begin
      use_taken_s[use_ptr_q]  = 1'b1;
      ce_valid_d[sel_s]       = 1'b1;
      slot_d[sel_s].data      = bus.use_data[use_ptr_q];
      slot_d[sel_s].byte_count = cur_count_s;
      use_ptr_d = (use_ptr_q == LAST_USE) ? '0 : use_ptr_q + PW'(1'b1);
      eng_ptr_d = (sel_s == LAST_CE) ? '0 : sel_s + IW'(1'b1);
      if (dispatch_count_q != 32'hFFFF_FFFF) begin
        dispatch_count_d = dispatch_count_q + 32'd1;
      end else begin
        dispatch_count_d = dispatch_count_q;
      end
    end else begin
      use_taken_s = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      use_ptr_q        <= '0;
      eng_ptr_q        <= '0;
      ce_valid_q       <= '0;
      slot_q           <= '0;
      dispatch_count_q <= 32'd0;
    end else begin
      use_ptr_q        <= use_ptr_d;
      eng_ptr_q        <= eng_ptr_d;
      ce_valid_q       <= ce_valid_d;
      slot_q           <= slot_d;
      dispatch_count_q <= dispatch_count_d;
    end
  end

  dispatch_order_fifo #(
    .DEPTH (ORDER_FIFO_DEPTH),
    .WIDTH (IW)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dispatch_s),
    .push_data (sel_s),
    .pop       (bus.order_ready),
    .full      (fifo_full_s),
    .valid     (fifo_valid_s),
    .head      (fifo_head_s)
  );

  for (genvar e = 0; e < NUM_COMPRESSION_ELEMENTS; e++) begin : g_ce_out
    assign bus.ce_data[e]       = slot_q[e].data;
    assign bus.ce_byte_count[e] = slot_q[e].byte_count;
  end

  assign bus.ce_valid       = ce_valid_q;
  assign bus.use_taken      = use_taken_s;
  assign bus.order_valid    = fifo_valid_s;
  assign bus.order_id       = fifo_head_s;
  assign bus.dispatch_count = dispatch_count_q;

endmodule

// File: tb/tb_use_dispatch_arbiter.sv
// Scenario bench for use_dispatch_arbiter: directed cases plus a randomized run against a queue model.
module tb_use_dispatch_arbiter;
  import use_dispatch_pkg::*;

  localparam int N  = 4;
  localparam int M  = 2;
  localparam int MB = 34;
  localparam int D  = 8;
  localparam int CW = count_width(MB);
  localparam int IW = id_width(M);
  localparam int DW = MB * 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   refill_mode;
  logic [N-1:0] taken_seen;

  // Reference model: slot occupancy, engine-order queue, token and engine pointers.
  int            m_use_ptr;
  int            m_eng_ptr;
  bit            m_busy [M];
  int            m_cnt  [M];
  logic [DW-1:0] m_data [M];
  int            m_fifo [$];
  longint        m_count;
  bit            e_disp;
  int            e_sel;
  logic [N-1:0]  e_taken;

  use_dispatch_arbiter_if #(
    .NUM_STREAM_ELEMENTS(N), .NUM_COMPRESSION_ELEMENTS(M), .MAX_UNCOMPRESSED_BYTES(MB)
  ) bus ();

  use_dispatch_arbiter #(
    .NUM_STREAM_ELEMENTS(N), .NUM_COMPRESSION_ELEMENTS(M),
    .MAX_UNCOMPRESSED_BYTES(MB), .ORDER_FIFO_DEPTH(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) v = (v << 32) | DW'($urandom());
    return v;
  endfunction

  task automatic load_use(input int i, input bit nonzero);
    int c;
    c = nonzero ? int'($urandom_range(MB, 1)) : int'($urandom_range(MB, 0));
    bus.use_byte_count[i] = CW'(c);
    bus.use_data[i]       = rand_data();
  endtask

  task automatic model_reset();
    m_use_ptr = 0;
    m_eng_ptr = 0;
    for (int e = 0; e < M; e++) begin
      m_busy[e] = 1'b0;
      m_cnt[e]  = 0;
      m_data[e] = '0;
    end
    m_fifo.delete();
    m_count = 0;
  endtask

  task automatic model_eval();
    e_sel = -1;
    for (int i = 0; i < M; i++) begin
      int k;
      k = (m_eng_ptr + i) % M;
      if (e_sel < 0 && !m_busy[k]) e_sel = k;
    end
    e_disp  = (bus.use_byte_count[m_use_ptr] != '0) && (e_sel >= 0) && (m_fifo.size() < D);
    e_taken = '0;
    if (e_disp) e_taken[m_use_ptr] = 1'b1;
  endtask

  task automatic model_commit();
    if (m_fifo.size() > 0 && bus.order_ready) void'(m_fifo.pop_front());
    for (int e = 0; e < M; e++) if (m_busy[e] && bus.ce_ready[e]) m_busy[e] = 1'b0;
    if (e_disp) begin
      m_busy[e_sel] = 1'b1;
      m_cnt[e_sel]  = int'(bus.use_byte_count[m_use_ptr]);
      m_data[e_sel] = bus.use_data[m_use_ptr];
      m_fifo.push_back(e_sel);
      m_use_ptr = (m_use_ptr + 1) % N;
      m_eng_ptr = (e_sel + 1) % M;
      if (m_count < 64'hFFFF_FFFF) m_count++;
    end
  endtask

  // One clock: advance the model, take the edge, let released USEs refill, return at negedge.
  task automatic cycle();
    #1;
    taken_seen = bus.use_taken;
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (taken_seen[i]) begin
        if (refill_mode == 0) bus.use_byte_count[i] = '0;
        else load_use(i, refill_mode == 1);
      end else if (refill_mode == 2 && bus.use_byte_count[i] == '0 && $urandom_range(1, 0) == 1) begin
        load_use(i, 1'b1);
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset              = 1'b0;
    bus.use_data       = '0;
    bus.use_byte_count = '0;
    bus.ce_ready       = '0;
    bus.order_ready    = 1'b0;
    refill_mode        = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) bus.use_byte_count[i] = CW'(7);
    bus.ce_ready    = '1;
    bus.order_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.ce_valid !== '0) begin errors++; $display("FAIL reset_ce_valid: got %b expected 0", bus.ce_valid); end
    checks++; if (bus.ce_byte_count !== '0) begin errors++; $display("FAIL reset_ce_byte_count: got %h expected 0", bus.ce_byte_count); end
    checks++; if (bus.ce_data !== '0) begin errors++; $display("FAIL reset_ce_data: got %h expected 0", bus.ce_data); end
    checks++; if (bus.order_valid !== 1'b0 || bus.order_id !== '0) begin errors++; $display("FAIL reset_order: got valid=%b id=%0d expected 0/0", bus.order_valid, bus.order_id); end
    checks++; if (bus.dispatch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.dispatch_count); end
    checks++; if (bus.use_taken !== '0) begin errors++; $display("FAIL reset_use_taken: got %b expected 0", bus.use_taken); end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    int cnts [N];
    logic [DW-1:0] dats [N];
    logic [N-1:0] exp_t;
    cnts = '{17, 20, 33, 18};
    apply_reset();
    bus.ce_ready = '1;
    for (int i = 0; i < N; i++) begin
      bus.use_byte_count[i] = CW'(cnts[i]);
      bus.use_data[i]       = rand_data();
      dats[i]               = bus.use_data[i];
    end
    for (int k = 0; k < N; k++) begin
      #1;
      exp_t = N'(1) << k;
      checks++; if (bus.use_taken !== exp_t) begin errors++; $display("FAIL b2b_taken[%0d]: got %b expected %b", k, bus.use_taken, exp_t); end
      cycle();
      checks++;
      if (bus.ce_valid[k % M] !== 1'b1 || bus.ce_byte_count[k % M] !== CW'(cnts[k]) || bus.ce_data[k % M] !== dats[k]) begin
        errors++;
        $display("FAIL b2b_ce%0d_rec%0d: got valid=%b count=%0d expected 1/%0d", k % M, k, bus.ce_valid[k % M], bus.ce_byte_count[k % M], cnts[k]);
      end
    end
    #1;
    checks++; if (bus.dispatch_count !== 32'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", bus.dispatch_count); end
    checks++; if (bus.use_taken !== '0) begin errors++; $display("FAIL b2b_idle_taken: got %b expected 0", bus.use_taken); end
    bus.order_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      #1;
      checks++;
      if (bus.order_valid !== 1'b1 || bus.order_id !== IW'(k % M)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got valid=%b id=%0d expected 1/%0d", k, bus.order_valid, bus.order_id, k % M);
      end
      cycle();
    end
    #1;
    checks++; if (bus.order_valid !== 1'b0) begin errors++; $display("FAIL b2b_order_drained: got %b expected 0", bus.order_valid); end
  endtask

  task automatic test_in_order();
    apply_reset();
    bus.ce_ready          = '1;
    bus.order_ready       = 1'b1;
    bus.use_byte_count[0] = CW'(5);
    bus.use_byte_count[2] = CW'(25);
    #1;
    checks++; if (bus.use_taken !== 4'b0001) begin errors++; $display("FAIL order_first: got %b expected 0001", bus.use_taken); end
    cycle();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.use_taken !== '0) begin errors++; $display("FAIL order_no_skip[%0d]: got %b expected 0000", c, bus.use_taken); end
      cycle();
    end
    checks++; if (bus.dispatch_count !== 32'd1) begin errors++; $display("FAIL order_count_hold: got %0d expected 1", bus.dispatch_count); end
    bus.use_byte_count[1] = CW'(19);
    #1;
    checks++; if (bus.use_taken !== 4'b0010) begin errors++; $display("FAIL order_use1: got %b expected 0010", bus.use_taken); end
    cycle();
    checks++; if (bus.ce_valid[1] !== 1'b1 || bus.ce_byte_count[1] !== CW'(19)) begin errors++; $display("FAIL order_ce1: got valid=%b count=%0d expected 1/19", bus.ce_valid[1], bus.ce_byte_count[1]); end
    #1;
    checks++; if (bus.use_taken !== 4'b0100) begin errors++; $display("FAIL order_use2: got %b expected 0100", bus.use_taken); end
    cycle();
    checks++; if (bus.ce_valid[0] !== 1'b1 || bus.ce_byte_count[0] !== CW'(25)) begin errors++; $display("FAIL order_ce0: got valid=%b count=%0d expected 1/25", bus.ce_valid[0], bus.ce_byte_count[0]); end
    checks++; if (bus.dispatch_count !== 32'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", bus.dispatch_count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0;
    logic [CW-1:0] c0;
    int n1;
    apply_reset();
    refill_mode     = 1;
    bus.ce_ready    = 2'b10;
    bus.order_ready = 1'b1;
    for (int i = 0; i < N; i++) load_use(i, 1'b1);
    d0 = bus.use_data[0];
    c0 = bus.use_byte_count[0];
    cycle();
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus.ce_valid[0] !== 1'b1 || bus.ce_data[0] !== d0 || bus.ce_byte_count[0] !== c0) begin
        errors++;
        $display("FAIL bp_ce0_stable[%0d]: got valid=%b count=%0d expected 1/%0d", c, bus.ce_valid[0], bus.ce_byte_count[0], c0);
      end
      if (bus.use_taken != '0) n1++;
      cycle();
    end
    checks++; if (n1 !== 5) begin errors++; $display("FAIL bp_ce1_rate: got %0d dispatches expected 5", n1); end
    bus.ce_ready = 2'b00;
    cycle();
    cycle();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.use_taken !== '0 || bus.ce_valid !== 2'b11) begin
        errors++;
        $display("FAIL bp_full_stall[%0d]: got taken=%b valid=%b expected 0000/11", c, bus.use_taken, bus.ce_valid);
      end
      cycle();
    end
    bus.ce_ready = 2'b01;
    #1;
    checks++; if (bus.use_taken !== '0) begin errors++; $display("FAIL bp_same_cycle_reuse: got %b expected 0000", bus.use_taken); end
    cycle();
    bus.ce_ready = 2'b00;
    #1;
    checks++;
    if (!$onehot(bus.use_taken) || bus.ce_valid !== 2'b10) begin
      errors++;
      $display("FAIL bp_resume: got taken=%b valid=%b expected one-hot/10", bus.use_taken, bus.ce_valid);
    end
    cycle();
    checks++; if (bus.ce_valid !== 2'b11) begin errors++; $display("FAIL bp_refill_ce0: got %b expected 11", bus.ce_valid); end
  endtask

  task automatic test_fifo_full();
    int nd;
    apply_reset();
    refill_mode     = 1;
    bus.ce_ready    = '1;
    bus.order_ready = 1'b0;
    for (int i = 0; i < N; i++) load_use(i, 1'b1);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.use_taken != '0) nd++;
      cycle();
    end
    checks++; if (nd !== D) begin errors++; $display("FAIL fifo_fill: got %0d dispatches expected %0d", nd, D); end
    checks++; if (bus.dispatch_count !== 32'(D)) begin errors++; $display("FAIL fifo_count: got %0d expected %0d", bus.dispatch_count, D); end
    bus.order_ready = 1'b1;
    #1;
    checks++; if (bus.use_taken !== '0 || bus.order_valid !== 1'b1) begin errors++; $display("FAIL fifo_pop_blocks: got taken=%b valid=%b expected 0000/1", bus.use_taken, bus.order_valid); end
    cycle();
    bus.order_ready = 1'b0;
    #1;
    checks++; if (bus.use_taken !== 4'b0001) begin errors++; $display("FAIL fifo_resume: got %b expected 0001", bus.use_taken); end
    cycle();
    checks++; if (bus.dispatch_count !== 32'(D + 1)) begin errors++; $display("FAIL fifo_count_after: got %0d expected %0d", bus.dispatch_count, D + 1); end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.ce_ready    = '1;
    bus.order_ready = 1'b1;
    force dut.dispatch_count_q = 32'hFFFF_FFFE;
    cycle();
    release dut.dispatch_count_q;
    #1;
    checks++; if (bus.dispatch_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h expected fffffffe", bus.dispatch_count); end
    for (int i = 0; i < 3; i++) load_use(i, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++; if (bus.dispatch_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold[%0d]: got %h expected ffffffff", k, bus.dispatch_count); end
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    bus.ce_ready    = 2'b11;
    bus.order_ready = 1'b0;
    for (int i = 0; i < 3; i++) load_use(i, 1'b1);
    cycle();
    cycle();
    bus.ce_ready = 2'b00;
    cycle();
    #1;
    checks++;
    if (bus.ce_valid !== 2'b11 || bus.dispatch_count !== 32'd3 || bus.order_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got valid=%b count=%0d ovalid=%b expected 11/3/1", bus.ce_valid, bus.dispatch_count, bus.order_valid);
    end
    #2;
    reset                 = 1'b0;
    bus.use_byte_count[0] = CW'(9);
    #1;
    checks++; if (bus.ce_valid !== '0 || bus.ce_byte_count !== '0 || bus.ce_data !== '0) begin errors++; $display("FAIL midrst_ce: got valid=%b counts=%h expected 0", bus.ce_valid, bus.ce_byte_count); end
    checks++; if (bus.order_valid !== 1'b0 || bus.order_id !== '0) begin errors++; $display("FAIL midrst_order: got valid=%b id=%0d expected 0/0", bus.order_valid, bus.order_id); end
    checks++; if (bus.dispatch_count !== 32'd0 || bus.use_taken !== '0) begin errors++; $display("FAIL midrst_count_taken: got %0d/%b expected 0/0000", bus.dispatch_count, bus.use_taken); end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    refill_mode = 2;
    for (int i = 0; i < N; i++) load_use(i, 1'b0);
    for (int c = 0; c < 400; c++) begin
      bus.ce_ready    = M'($urandom());
      bus.order_ready = ($urandom_range(3, 0) != 0);
      #1;
      model_eval();
      checks++; if (bus.use_taken !== e_taken) begin errors++; $display("FAIL rnd_taken[%0d]: got %b expected %b", c, bus.use_taken, e_taken); end
      for (int e = 0; e < M; e++) begin
        checks++; if (bus.ce_valid[e] !== m_busy[e]) begin errors++; $display("FAIL rnd_ce_valid[%0d][%0d]: got %b expected %b", c, e, bus.ce_valid[e], m_busy[e]); end
        if (m_busy[e]) begin
          checks++;
          if (bus.ce_byte_count[e] !== CW'(m_cnt[e]) || bus.ce_data[e] !== m_data[e]) begin
            errors++;
            $display("FAIL rnd_ce_rec[%0d][%0d]: got count=%0d expected %0d", c, e, bus.ce_byte_count[e], m_cnt[e]);
          end
        end
      end
      checks++; if (bus.order_valid !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_order_valid[%0d]: got %b expected %0d", c, bus.order_valid, m_fifo.size() > 0); end
      if (m_fifo.size() > 0) begin
        checks++; if (bus.order_id !== IW'(m_fifo[0])) begin errors++; $display("FAIL rnd_order_id[%0d]: got %0d expected %0d", c, bus.order_id, m_fifo[0]); end
      end
      checks++; if (bus.dispatch_count !== 32'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, bus.dispatch_count, m_count); end
      cycle();
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    refill_mode        = 0;
    reset              = 1'b0;
    bus.use_data       = '0;
    bus.use_byte_count = '0;
    bus.ce_ready       = '0;
    bus.order_ready    = 1'b0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_in_order();
    test_backpressure();
    test_fifo_full();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
